// File: rtl/flip_icon_store.sv
// flip_icon_store
//   Loadable icon memory sitting in front of flip_engine's icon read port.
//   Icons arrive over a valid/ready write channel while the store is in LOAD.
//   flip_engine reads them back in READY with a fixed 1-cycle latency.
//
// Ports
//   clk_i, rst_ni                clock, async active-low reset
//   flush_i                      sync clear back to IDLE, count = 0
//   load_start_i                 start (or restart) a load
//   icon_valid_i/icon_i/
//   icon_last_i/icon_ready_o     write channel
//   load_done_o                  high while icons are usable (READY)
//   flip_ren_i/flip_raddr_i      read request from flip_engine
//   flip_rdata_o                 read data, one cycle after flip_ren_i
//   icon_last_raddr_plus_one_o   number of icons loaded
//   rd_err_o                     sticky illegal-read flag
module flip_icon_store #(
  parameter int NUM_SPIN        = 256,
  parameter int FLIP_ICON_DEPTH = 1024,
  parameter int ADDR_W          = $clog2(FLIP_ICON_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                load_start_i,
  input  logic                icon_valid_i,
  input  logic [NUM_SPIN-1:0] icon_i,
  input  logic                icon_last_i,
  output logic                icon_ready_o,
  output logic                load_done_o,
  input  logic                flip_ren_i,
  input  logic [ADDR_W:0]     flip_raddr_i,
  output logic [NUM_SPIN-1:0] flip_rdata_o,
  output logic [ADDR_W:0]     icon_last_raddr_plus_one_o,
  output logic                rd_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(FLIP_ICON_DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wptr_q;
  logic [ADDR_W:0]     count_q;
  logic                rd_err_q;
  logic [NUM_SPIN-1:0] rdata_p1;
  logic [NUM_SPIN-1:0] mem [FLIP_ICON_DEPTH];

  logic hs;
  logic load_end;
  logic rd_legal;

  // A handshake in the same cycle as a flush or restart is dropped.
  assign icon_ready_o = (state_q == LOAD);
  assign hs           = icon_valid_i & icon_ready_o & ~flush_i & ~load_start_i;
  // Either the producer marks the last icon, or the memory is full.
  assign load_end     = hs & (icon_last_i | (wptr_q == LAST_IDX));
  // Range check on the full ADDR_W+1 address before any memory indexing.
  assign rd_legal     = (state_q == READY) & (flip_raddr_i < count_q);

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (load_start_i) begin
      state_d = LOAD;
    end else if (load_end) begin
      state_d = READY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      count_q  <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_i || load_start_i) begin
        wptr_q   <= '0;
        count_q  <= '0;
        rd_err_q <= 1'b0;
      end else begin
        if (hs) begin
          wptr_q <= wptr_q + 1'b1;
        end
        // Count lands on the same edge that raises load_done_o.
        if (load_end) begin
          count_q <= wptr_q + 1'b1;
        end
        if (flip_ren_i && !rd_legal) begin
          rd_err_q <= 1'b1;
        end
      end
    end
  end

  // Icon storage: not reset, only written on an accepted handshake.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      mem[wptr_q[ADDR_W-1:0]] <= icon_i;
    end
  end

  // Stage p0 -> p1: registered read, held until the next accepted read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_p1 <= '0;
    end else if (flush_i) begin
      rdata_p1 <= '0;
    end else if (flip_ren_i) begin
      rdata_p1 <= rd_legal ? mem[flip_raddr_i[ADDR_W-1:0]] : '0;
    end
  end

  assign flip_rdata_o               = rdata_p1;
  assign load_done_o                = (state_q == READY);
  assign icon_last_raddr_plus_one_o = count_q;
  assign rd_err_o                   = rd_err_q;

endmodule

// File: tb/tb_flip_icon_store.sv
module tb_flip_icon_store;

  localparam int NUM_SPIN = 32;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 3;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                flush_i;
  logic                load_start_i;
  logic                icon_valid_i;
  logic [NUM_SPIN-1:0] icon_i;
  logic                icon_last_i;
  logic                icon_ready_o;
  logic                load_done_o;
  logic                flip_ren_i;
  logic [ADDR_W:0]     flip_raddr_i;
  logic [NUM_SPIN-1:0] flip_rdata_o;
  logic [ADDR_W:0]     icon_last_raddr_plus_one_o;
  logic                rd_err_o;

  int total = 0;
  int bad   = 0;

  flip_icon_store #(
    .NUM_SPIN(NUM_SPIN),
    .FLIP_ICON_DEPTH(DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .load_start_i(load_start_i),
    .icon_valid_i(icon_valid_i),
    .icon_i(icon_i),
    .icon_last_i(icon_last_i),
    .icon_ready_o(icon_ready_o),
    .load_done_o(load_done_o),
    .flip_ren_i(flip_ren_i),
    .flip_raddr_i(flip_raddr_i),
    .flip_rdata_o(flip_rdata_o),
    .icon_last_raddr_plus_one_o(icon_last_raddr_plus_one_o),
    .rd_err_o(rd_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i      = 1'b0;
    load_start_i = 1'b0;
    icon_valid_i = 1'b0;
    icon_i       = '0;
    icon_last_i  = 1'b0;
    flip_ren_i   = 1'b0;
    flip_raddr_i = '0;
  endtask

  task automatic push(input logic [NUM_SPIN-1:0] v, input logic last);
    icon_valid_i = 1'b1;
    icon_i       = v;
    icon_last_i  = last;
    step();
    icon_valid_i = 1'b0;
    icon_last_i  = 1'b0;
  endtask

  task automatic rd(input int a);
    flip_ren_i   = 1'b1;
    flip_raddr_i = (ADDR_W+1)'(a);
    step();
    flip_ren_i   = 1'b0;
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    chk("rst_ready", icon_ready_o, 0);
    chk("rst_done", load_done_o, 0);
    chk("rst_count", icon_last_raddr_plus_one_o, 0);
    chk("rst_rdata", flip_rdata_o, 0);
    chk("rst_err", rd_err_o, 0);
    rst_ni = 1'b1;
    step();

    // Full load of four icons, then back-to-back reads.
    start_load();
    chk("load_ready", icon_ready_o, 1);
    chk("load_notdone", load_done_o, 0);
    push(32'h1, 1'b0);
    push(32'h2, 1'b0);
    push(32'h4, 1'b0);
    chk("load_3_notdone", load_done_o, 0);
    push(32'h8, 1'b1);
    chk("full_count", icon_last_raddr_plus_one_o, 4);
    chk("full_done", load_done_o, 1);
    chk("full_ready_low", icon_ready_o, 0);
    flip_ren_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flip_raddr_i = (ADDR_W+1)'(i);
      step();
      chk($sformatf("b2b_rd%0d", i), flip_rdata_o, 64'(1) << i);
    end
    flip_ren_i = 1'b0;
    step();
    chk("rdata_hold", flip_rdata_o, 32'h8);
    chk("no_err", rd_err_o, 0);

    // Out-of-range read and stickiness.
    rd(4);
    chk("oor_rdata", flip_rdata_o, 0);
    chk("oor_err", rd_err_o, 1);
    step();
    chk("oor_err_sticky", rd_err_o, 1);
    rd(1);
    chk("legal_after_err", flip_rdata_o, 32'h2);
    chk("err_sticky_legal", rd_err_o, 1);

    // Reload with two icons.
    start_load();
    chk("reload_err_clr", rd_err_o, 0);
    chk("reload_count0", icon_last_raddr_plus_one_o, 0);
    chk("reload_notdone", load_done_o, 0);
    push(32'hA, 1'b0);
    push(32'hB, 1'b1);
    chk("reload_count", icon_last_raddr_plus_one_o, 2);
    rd(0);
    chk("reload_rd0", flip_rdata_o, 32'hA);
    rd(1);
    chk("reload_rd1", flip_rdata_o, 32'hB);
    chk("reload_noerr", rd_err_o, 0);
    rd(2);
    chk("reload_rd2_rdata", flip_rdata_o, 0);
    chk("reload_rd2_err", rd_err_o, 1);

    // Read during LOAD, then depth cap with 10 icons and no last.
    start_load();
    rd(0);
    chk("ld_rd_rdata", flip_rdata_o, 0);
    chk("ld_rd_err", rd_err_o, 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("cap_ready%0d", i), icon_ready_o, (i < 8) ? 1 : 0);
      push(32'h100 + 32'(i), 1'b0);
    end
    chk("cap_count", icon_last_raddr_plus_one_o, 8);
    chk("cap_done", load_done_o, 1);
    chk("cap_err_sticky", rd_err_o, 1);
    rd(7);
    chk("cap_rd7", flip_rdata_o, 32'h107);
    rd(8);
    chk("cap_rd8", flip_rdata_o, 0);

    // Restart mid-load drops the concurrent handshake.
    start_load();
    push(32'h55, 1'b0);
    load_start_i = 1'b1;
    push(32'h66, 1'b1);
    load_start_i = 1'b0;
    chk("restart_still_load", load_done_o, 0);
    push(32'h77, 1'b1);
    chk("restart_count", icon_last_raddr_plus_one_o, 1);
    rd(0);
    chk("restart_rd0", flip_rdata_o, 32'h77);

    // Flush after 3 of 5 icons, with a handshake pending in the flush cycle.
    start_load();
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    push(32'h33, 1'b0);
    flush_i = 1'b1;
    push(32'h44, 1'b0);
    flush_i = 1'b0;
    chk("flush_ready", icon_ready_o, 0);
    chk("flush_done", load_done_o, 0);
    chk("flush_count", icon_last_raddr_plus_one_o, 0);
    chk("flush_rdata", flip_rdata_o, 0);
    rd(0);
    chk("idle_rd_err", rd_err_o, 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_err_clr", rd_err_o, 0);

    // Async reset in the middle of a load.
    start_load();
    push(32'h91, 1'b0);
    push(32'h92, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("arst_ready", icon_ready_o, 0);
    chk("arst_done", load_done_o, 0);
    chk("arst_count", icon_last_raddr_plus_one_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    start_load();
    push(32'hC3, 1'b1);
    chk("post_rst_count", icon_last_raddr_plus_one_o, 1);
    chk("post_rst_done", load_done_o, 1);
    rd(0);
    chk("post_rst_rd0", flip_rdata_o, 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Upper bound on run time in case the stimulus stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
